// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle demodulator: synchronises an asynchronous PWM input, measures
// the high time and period of each cycle and divides them into an unsigned
// duty fraction with a one-cycle valid strobe. Also flags stuck inputs and
// periods too short to measure.
module pwm_duty_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DUTY_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [CNT_W-1:0]  period,
  output logic              stuck_hi,
  output logic              stuck_lo,
  output logic              short_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [DUTY_W-1:0] DutyMax  = '1;
  localparam logic [CNT_W-1:0]  ShortLim = CNT_W'(DUTY_W + 2);
  localparam int unsigned       IterW    = $clog2(DUTY_W + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StMeasure = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic                   edge_det;
  logic                   timeout;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic              busy_q, busy_d;
  logic [IterW-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  den_q, den_d;
  // Holds the first DUTY_W-1 quotient bits; the last bit joins on completion.
  logic [DUTY_W-2:0] quo_q, quo_d;
  logic              clamp_q, clamp_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              duty_valid_q, duty_valid_d;
  logic              stuck_hi_q, stuck_hi_d;
  logic              stuck_lo_q, stuck_lo_d;
  logic              short_err_q, short_err_d;

  logic [CNT_W:0]    rem_shift;
  logic              rem_ge;

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_d_q;
  // An edge in the same cycle as the timeout wins.
  assign timeout  = en && !edge_det && (state_q != StIdle) && (period_cnt_q == CntMax);

  assign rem_shift = {rem_q, 1'b0};
  assign rem_ge    = rem_shift >= {1'b0, den_q};

  // Input synchroniser and one-cycle-delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  // Next-state logic: FSM, counters, restoring divider and result registers.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    busy_d       = busy_q;
    iter_d       = iter_q;
    rem_d        = rem_q;
    den_d        = den_q;
    quo_d        = quo_q;
    clamp_d      = clamp_q;
    duty_d       = duty_q;
    period_d     = period_q;
    duty_valid_d = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;
    short_err_d  = 1'b0;

    if (!en) begin
      // Disable aborts any divide without a strobe; results hold, flags clear.
      state_d      = StIdle;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      busy_d       = 1'b0;
      iter_d       = '0;
      stuck_hi_d   = 1'b0;
      stuck_lo_d   = 1'b0;
    end else begin
      if (busy_q) begin
        rem_d  = rem_ge ? CNT_W'(rem_shift - {1'b0, den_q}) : rem_shift[CNT_W-1:0];
        quo_d  = {quo_q[DUTY_W-3:0], rem_ge};
        iter_d = iter_q + IterW'(1);
        if (iter_q == IterW'(DUTY_W - 1)) begin
          busy_d       = 1'b0;
          duty_valid_d = 1'b1;
          duty_d       = clamp_q ? DutyMax : {quo_q, rem_ge};
          period_d     = den_q;
          stuck_hi_d   = 1'b0;
          stuck_lo_d   = 1'b0;
        end
      end

      case (state_q)
        StAcquire: begin
          if (edge_det) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            state_d      = StMeasure;
          end else if (period_cnt_q != CntMax) begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
          end
        end
        StMeasure: begin
          if (edge_det) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            if (period_cnt_q < ShortLim) begin
              short_err_d = 1'b1;
            end else begin
              // Numerator H*2^DUTY_W: since H < P the top CNT_W quotient bits
              // are zero, so the partial remainder starts at H directly.
              busy_d  = 1'b1;
              iter_d  = '0;
              den_d   = period_cnt_q;
              clamp_d = high_cnt_q >= period_cnt_q;
              rem_d   = (high_cnt_q >= period_cnt_q) ? '0 : high_cnt_q;
              quo_d   = '0;
            end
          end else begin
            if (period_cnt_q != CntMax) begin
              period_cnt_d = period_cnt_q + CNT_W'(1);
            end
            if (s && (high_cnt_q != CntMax)) begin
              high_cnt_d = high_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d      = StAcquire;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end
      endcase

      if (timeout) begin
        stuck_hi_d   = s;
        stuck_lo_d   = ~s;
        duty_d       = s ? DutyMax : '0;
        period_d     = CntMax;
        duty_valid_d = 1'b1;
        state_d      = StAcquire;
        period_cnt_d = '0;
        high_cnt_d   = '0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      busy_q       <= 1'b0;
      iter_q       <= '0;
      rem_q        <= '0;
      den_q        <= '0;
      quo_q        <= '0;
      clamp_q      <= 1'b0;
      duty_q       <= '0;
      period_q     <= '0;
      duty_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
      short_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      busy_q       <= busy_d;
      iter_q       <= iter_d;
      rem_q        <= rem_d;
      den_q        <= den_d;
      quo_q        <= quo_d;
      clamp_q      <= clamp_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      duty_valid_q <= duty_valid_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
      short_err_q  <= short_err_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign period     = period_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;
  assign short_err  = short_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: drives PWM periods, predicts each strobe from the
// driven high time and period, and compares against recorded DUT strobes.
module tb_pwm_duty_meter;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DUTY_W = 10;
  localparam int unsigned SYNC   = 2;
  // Clock edges from the edge that samples a pwm rise to the sample showing duty_valid.
  localparam int LAT = 1 + SYNC + DUTY_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              pwm_in;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic [CNT_W-1:0]  period;
  logic              stuck_hi;
  logic              stuck_lo;
  logic              short_err;
  logic              busy;

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .DUTY_W     (DUTY_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .duty_valid(duty_valid),
    .period    (period),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo),
    .short_err (short_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    int shi;
    int slo;
    int cyc;
    int blen;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   rise_q[$];
  int   cyc       = 0;
  int   blen      = 0;
  int   short_cnt = 0;

  int checks = 0;
  int errors = 0;
  int got_rd = 0;
  int short_base = 0;
  int exp_short = 0;
  bit armed = 0;
  int prev_n = 0;
  int prev_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      got_q.push_back('{duty: int'(duty), period: int'(period), shi: int'(stuck_hi),
                        slo: int'(stuck_lo), cyc: cyc, blen: blen});
    end
    blen      <= (busy === 1'b1) ? blen + 1 : 0;
    short_cnt <= short_cnt + ((short_err === 1'b1) ? 1 : 0);
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A rise closes the previous period; predict its outcome from N and K alone.
  task automatic rise();
    @(negedge clk);
    pwm_in = 1'b1;
    rise_q.push_back(cyc);
    if (armed) begin
      if (prev_n < int'(DUTY_W) + 2) exp_short++;
      else exp_q.push_back('{duty: (prev_k * (1 << DUTY_W)) / prev_n, period: prev_n,
                             shi: 0, slo: 0, cyc: 0, blen: DUTY_W});
    end
    armed = 1'b1;
  endtask

  task automatic drive_period(input int n, input int k);
    rise();
    prev_n = n;
    prev_k = k;
    repeat (k) @(negedge clk);
    pwm_in = 1'b0;
    repeat (n - k - 1) @(negedge clk);
  endtask

  task automatic check_strobes(input string tag);
    int n_got = got_q.size() - got_rd;
    chk({tag, "_count"}, n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      chk({tag, "_duty"},   got_q[got_rd+i].duty,   exp_q[i].duty);
      chk({tag, "_period"}, got_q[got_rd+i].period, exp_q[i].period);
      chk({tag, "_shi"},    got_q[got_rd+i].shi,    exp_q[i].shi);
      chk({tag, "_slo"},    got_q[got_rd+i].slo,    exp_q[i].slo);
      chk({tag, "_busy_len"}, got_q[got_rd+i].blen, exp_q[i].blen);
    end
    chk({tag, "_short"}, short_cnt - short_base, exp_short);
    got_rd     = got_q.size();
    short_base = short_cnt;
    exp_q.delete();
    exp_short  = 0;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 40 && busy !== 1'b1; i++) @(negedge clk);
    chk(tag, busy, 1);
  endtask

  initial begin
    int base;
    int n;
    int k;
    rst_n  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_valid", duty_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_shi", stuck_hi, 0);
    chk("rst_slo", stuck_lo, 0);
    chk("rst_short", short_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);

    // K=50 of N=1000; first strobe only after the second rise.
    rise_q.delete();
    base = got_q.size();
    repeat (3) drive_period(1000, 50);
    if (got_q.size() > base) chk("latency", got_q[base].cyc - rise_q[1], LAT);
    check_strobes("k50");

    drive_period(1000, 900);
    repeat (2) drive_period(1000, 500);
    check_strobes("step");

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(20, 300);
      k = $urandom_range(1, n - 1);
      drive_period(n, k);
    end
    check_strobes("rand");

    repeat (5) drive_period(8, 4);
    repeat (2) drive_period(1000, 500);
    check_strobes("short");

    // Hold high past the timeout.
    rise();
    exp_q.push_back('{duty: (1 << DUTY_W) - 1, period: (1 << CNT_W) - 1, shi: 1, slo: 0,
                      cyc: 0, blen: 0});
    armed = 1'b0;
    repeat (66000) @(negedge clk);
    chk("stuck_hi_flag", stuck_hi, 1);
    chk("stuck_lo_flag", stuck_lo, 0);
    chk("stuck_duty", duty, (1 << DUTY_W) - 1);
    chk("stuck_period", period, (1 << CNT_W) - 1);
    check_strobes("stuck");
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    repeat (3) drive_period(300, 100);
    check_strobes("restore");
    chk("restore_shi", stuck_hi, 0);

    // Reset while the divider runs.
    armed = 1'b0;
    rise();
    wait_busy("rst_busy_seen");
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("midrst_duty", duty, 0);
    chk("midrst_period", period, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", duty_valid, 0);
    chk("midrst_shi", stuck_hi, 0);
    chk("midrst_short", short_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    repeat (300) @(negedge clk);
    repeat (3) drive_period(300, 100);
    check_strobes("post_rst");

    // Disable while the divider runs: no strobe, results hold.
    armed = 1'b0;
    rise();
    wait_busy("en_busy_seen");
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en_off_busy", busy, 0);
    chk("en_off_duty", duty, (100 * (1 << DUTY_W)) / 300);
    chk("en_off_period", period, 300);
    chk("en_off_shi", stuck_hi, 0);
    chk("en_off_slo", stuck_lo, 0);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    armed = 1'b0;
    en = 1'b1;
    repeat (3) drive_period(300, 200);
    check_strobes("reen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
